tlb_op_ctrl: RTL and testbench
==============================

// Module: tlb_op_ctrl
// PURPOSE
//  Sequences the CP0 TLB instructions (TLBP, TLBR, TLBWI, TLBWR) against the TLB array. Sits between
//  the MEM-stage CP0 unit and the TLB: owns tlb index/we, the CP0 Random register, Index/EntryHi/EntryLo/
//  PageMask write-back, and the translation hold that covers the TLB's registered lookup ports.
// PARAMETERS
//  TLB_NUM   32  number of TLB entries
//  IDX_BITS  5   index width, clog2(TLB_NUM)
// PORTS
//  clk              in   1         clock
//  rst_n            in   1         reset, asynchronous, active-low
//  op_valid         in   1         TLB instruction request
//  op_code          in   2         00 TLBP, 01 TLBR, 10 TLBWI, 11 TLBWR
//  op_ready         out  1         controller idle; request accepted when op_valid & op_ready & ~flush
//  op_done          out  1         one-cycle pulse, instruction retired
//  flush            in   1         pipeline flush (exception/eret)
//  cp0_index_i      in   IDX_BITS  CP0 Index[IDX_BITS-1:0]
//  cp0_wired_i      in   IDX_BITS  CP0 Wired
//  cp0_wired_we     in   1         Wired written this cycle
//  cp0_entryhi_i    in   32        CP0 EntryHi (expected data for write check)
//  cp0_entrylo0_i   in   32        CP0 EntryLo0
//  cp0_entrylo1_i   in   32        CP0 EntryLo1
//  cp0_mask_i       in   12        CP0 PageMask[24:13]
//  tlb_we           out  1         TLB write strobe
//  tlb_index        out  IDX_BITS  TLB read/write index
//  tlb_probe_i      in   32        TLB probe result {miss, .., index}
//  tlb_entryhi_i    in   32        TLB readback EntryHi
//  tlb_entrylo0_i   in   32        TLB readback EntryLo0
//  tlb_entrylo1_i   in   32        TLB readback EntryLo1
//  tlb_mask_i       in   12        TLB readback mask
//  cp0_index_we     out  1         write cp0_index_o to CP0 Index
//  cp0_index_o      out  32        {probe miss, 0.., probe index}
//  cp0_read_we      out  1         write EntryHi/Lo0/Lo1/PageMask from read data
//  cp0_entryhi_o / cp0_entrylo0_o / cp0_entrylo1_o  out 32 each  captured TLBR data
//  cp0_pagemask_o   out  32        {7'b0, mask, 13'b0}
//  random_o         out  IDX_BITS  CP0 Random
//  translate_hold   out  1         stall fetch/LSU translation
//  check_err        out  1         write-readback mismatch pulse (TLB_WRITE_CHECK_EN only)
// BEHAVIOUR
//  - Reset: state IDLE, op_ready=1, random_o=TLB_NUM-1, every other output 0.
//  - States: IDLE, PROBE, READ, WRITE, SETTLE, CHECK, COMMIT. op_ready=1 only in IDLE.
//  - Accept (cycle T): latch op; latch idx = TLBWR ? random_o : cp0_index_i. tlb_index=idx in all non-IDLE states.
//  - TLBP: T+1 PROBE, register tlb_probe_i; T+2 COMMIT: cp0_index_we=1, op_done=1.
//  - TLBR: T+1 READ, register readback; T+2 COMMIT: cp0_read_we=1, op_done=1.
//  - TLBWI/TLBWR: T+1 WRITE (tlb_we=1, exactly one cycle); T+2 SETTLE; [CHECK]; COMMIT op_done=1.
//    translate_hold=1 in WRITE, SETTLE, CHECK; 0 otherwise.
//  - flush in IDLE blocks acceptance; flush in PROBE/READ -> IDLE, no write-back, no op_done.
//    From WRITE onward flush is ignored: the write is architecturally committed and completes.
//  - COMMIT -> IDLE unconditionally; back-to-back ops: next accept earliest cycle after COMMIT.
//  - Random: decrements every cycle; at value <= cp0_wired_i it wraps to TLB_NUM-1. cp0_wired_we -> TLB_NUM-1
//    next cycle (priority over decrement). cp0_wired_i >= TLB_NUM-1 holds TLB_NUM-1. Runs during ops.
// CONFIGURATION
//  TLB_WRITE_CHECK_EN defined: SETTLE -> CHECK -> COMMIT; CHECK compares readback against
//   {entryhi[31:13]&~mask, 5'b0, asid}, {6'b0, pfn&~mask, C, D, V, G0&G1} per EntryLo and mask;
//   mismatch -> check_err=1 in COMMIT. Undefined: SETTLE -> COMMIT, no CHECK state, check_err tied 0.
// STRUCTURE
//  tlb_pkg: tlb_op_e (op_code enum), tlb_ctrl_state_e, TLB_PROBE_MISS_BIT=31, PAGEMASK_LSB=13.
//  Sub-module tlb_random_ctr: Random counter with wired/wrap logic.
// TESTING
//  1. Reset release -> random_o=31, op_ready=1, tlb_we=0, op_done=0, translate_hold=0.
//  2. TLBWI, cp0_index_i=5 at T -> tlb_we=1 & tlb_index=5 only at T+1; hold T+1..T+2; op_done T+3.
//  3. TLBP, entry 7 matches -> cp0_index_we & cp0_index_o=0x7 at T+2; no match -> 0x8000_0000.
//  4. Wired=4 -> random 31..4 then 31; cp0_wired_we at 10 -> 31 next cycle; TLBWR writes sampled Random.
//  5. TLBR accepted, flush at T+1 -> no cp0_read_we, no op_done, op_ready=1 at T+2; flush at WRITE -> completes.
//  6. TLB_WRITE_CHECK_EN, readback PFN bit forced -> check_err=1 with op_done at T+4; clean write -> 0.

Source files
------------

// File: rtl/tlb_pkg.sv
// -----------------------------------------------------------------------------
// tlb_pkg
//  Shared types and constants for the CP0 TLB instruction controller.
//  - tlb_op_e          : encoding of op_code (TLBP/TLBR/TLBWI/TLBWR)
//  - tlb_ctrl_state_e  : controller FSM states
//  - TLB_PROBE_MISS_BIT: bit of the probe result / CP0 Index that flags a miss
//  - PAGEMASK_LSB      : LSB position of the mask field inside CP0 PageMask
// -----------------------------------------------------------------------------
package tlb_pkg;

  typedef enum logic [1:0] {
    OP_TLBP  = 2'b00,
    OP_TLBR  = 2'b01,
    OP_TLBWI = 2'b10,
    OP_TLBWR = 2'b11
  } tlb_op_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_PROBE  = 3'd1,
    ST_READ   = 3'd2,
    ST_WRITE  = 3'd3,
    ST_SETTLE = 3'd4,
    ST_CHECK  = 3'd5,
    ST_COMMIT = 3'd6
  } tlb_ctrl_state_e;

  localparam int TLB_PROBE_MISS_BIT = 31;
  localparam int PAGEMASK_LSB       = 13;

endpackage

// File: rtl/tlb_random_ctr.sv
// -----------------------------------------------------------------------------
// tlb_random_ctr
//  CP0 Random register. Free-running down-counter over [Wired, TLB_NUM-1].
//  Ports:
//    clk, rst_n    : clock, asynchronous active-low reset
//    cp0_wired_i   : current CP0 Wired value
//    cp0_wired_we  : Wired written this cycle -> Random reloads to TLB_NUM-1
//    random_o      : current Random value (reset value TLB_NUM-1)
// -----------------------------------------------------------------------------
module tlb_random_ctr #(
  parameter int TLB_NUM  = 32,
  parameter int IDX_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [IDX_BITS-1:0] cp0_wired_i,
  input  logic                cp0_wired_we,
  output logic [IDX_BITS-1:0] random_o
);

  localparam logic [IDX_BITS-1:0] RAND_TOP = IDX_BITS'(TLB_NUM - 1);

  // Reload to the top on a Wired write, when Wired leaves no range to count
  // through, or once the counter has reached the wired floor.
  logic reload;
  assign reload = cp0_wired_we || (cp0_wired_i >= RAND_TOP) || (random_o <= cp0_wired_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      random_o <= RAND_TOP;
    end else if (reload) begin
      random_o <= RAND_TOP;
    end else begin
      random_o <= random_o - 1'b1;
    end
  end

endmodule

// File: rtl/tlb_op_ctrl.sv
// -----------------------------------------------------------------------------
// tlb_op_ctrl
//  Sequences CP0 TLB instructions (TLBP, TLBR, TLBWI, TLBWR) against the TLB
//  array: drives the TLB index/write strobe, owns CP0 Random, produces the
//  Index / EntryHi / EntryLo0 / EntryLo1 / PageMask write-back and holds
//  translation while a TLB write is settling through the registered lookups.
//
//  Ports:
//    op_valid/op_code/op_ready/op_done : instruction handshake, op_done pulses on retire
//    flush                             : pipeline flush; kills PROBE/READ, ignored from WRITE on
//    cp0_*_i, cp0_wired_we             : CP0 register state
//    tlb_we, tlb_index                 : TLB write strobe and read/write index
//    tlb_probe_i, tlb_*_i              : TLB probe result and readback data
//    cp0_index_we/cp0_index_o          : TLBP result write-back
//    cp0_read_we/cp0_*_o               : TLBR result write-back
//    random_o                          : CP0 Random
//    translate_hold                    : stall fetch/LSU translation
//    check_err                         : write-readback mismatch, valid with op_done
//
//  Build option: TLB_WRITE_CHECK_EN adds a CHECK state after SETTLE that
//  compares the TLB readback against the written CP0 values; when undefined
//  SETTLE goes straight to COMMIT and check_err is tied low.
// -----------------------------------------------------------------------------
module tlb_op_ctrl
  import tlb_pkg::*;
#(
  parameter int TLB_NUM  = 32,
  parameter int IDX_BITS = 5
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                op_valid,
  input  logic [1:0]          op_code,
  output logic                op_ready,
  output logic                op_done,
  input  logic                flush,
  input  logic [IDX_BITS-1:0] cp0_index_i,
  input  logic [IDX_BITS-1:0] cp0_wired_i,
  input  logic                cp0_wired_we,
  input  logic [31:0]         cp0_entryhi_i,
  input  logic [31:0]         cp0_entrylo0_i,
  input  logic [31:0]         cp0_entrylo1_i,
  input  logic [11:0]         cp0_mask_i,
  output logic                tlb_we,
  output logic [IDX_BITS-1:0] tlb_index,
  input  logic [31:0]         tlb_probe_i,
  input  logic [31:0]         tlb_entryhi_i,
  input  logic [31:0]         tlb_entrylo0_i,
  input  logic [31:0]         tlb_entrylo1_i,
  input  logic [11:0]         tlb_mask_i,
  output logic                cp0_index_we,
  output logic [31:0]         cp0_index_o,
  output logic                cp0_read_we,
  output logic [31:0]         cp0_entryhi_o,
  output logic [31:0]         cp0_entrylo0_o,
  output logic [31:0]         cp0_entrylo1_o,
  output logic [31:0]         cp0_pagemask_o,
  output logic [IDX_BITS-1:0] random_o,
  output logic                translate_hold,
  output logic                check_err
);

  tlb_ctrl_state_e     state_q;
  tlb_op_e             op_q;
  logic [IDX_BITS-1:0] idx_q;
  logic [11:0]         mask_q;
  logic                accept;
  logic [31:0]         probe_index;

  tlb_random_ctr #(
    .TLB_NUM  (TLB_NUM),
    .IDX_BITS (IDX_BITS)
  ) u_random (
    .clk          (clk),
    .rst_n        (rst_n),
    .cp0_wired_i  (cp0_wired_i),
    .cp0_wired_we (cp0_wired_we),
    .random_o     (random_o)
  );

  assign accept = op_valid && !flush;

  // Only the miss flag and the index field of the probe result reach CP0 Index.
  assign probe_index = {tlb_probe_i[TLB_PROBE_MISS_BIT],
                        {(31 - IDX_BITS){1'b0}},
                        tlb_probe_i[IDX_BITS-1:0]};

  logic unused_probe_bits;
  assign unused_probe_bits = ^tlb_probe_i[30:IDX_BITS];

`ifdef TLB_WRITE_CHECK_EN
  // Canonical forms the TLB stores: masked VPN2 bits and EntryHi[12:8] read
  // back as zero, masked PFN bits read back as zero and G is the AND of both G bits.
  function automatic logic [31:0] exp_entryhi(input logic [31:0] hi, input logic [11:0] mask);
    return {hi[31:25], hi[24:13] & ~mask, 5'b0, hi[7:0]};
  endfunction

  function automatic logic [31:0] exp_entrylo(input logic [31:0] lo, input logic [11:0] mask,
                                              input logic g);
    return {6'b0, lo[25:18], lo[17:6] & ~mask, lo[5:1], g};
  endfunction

  logic g_both;
  logic mismatch;
  logic chk_err_q;

  assign g_both   = cp0_entrylo0_i[0] & cp0_entrylo1_i[0];
  assign mismatch = (tlb_entryhi_i  != exp_entryhi(cp0_entryhi_i, cp0_mask_i))         ||
                    (tlb_entrylo0_i != exp_entrylo(cp0_entrylo0_i, cp0_mask_i, g_both)) ||
                    (tlb_entrylo1_i != exp_entrylo(cp0_entrylo1_i, cp0_mask_i, g_both)) ||
                    (tlb_mask_i     != cp0_mask_i);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      chk_err_q <= 1'b0;
    end else if (state_q == ST_WRITE) begin
      chk_err_q <= 1'b0;
    end else if (state_q == ST_CHECK) begin
      chk_err_q <= mismatch;
    end
  end

  assign check_err = (state_q == ST_COMMIT) && chk_err_q;

  logic unused_check_bits;
  assign unused_check_bits = ^{cp0_entryhi_i[12:8], cp0_entrylo0_i[31:26], cp0_entrylo1_i[31:26]};
`else
  assign check_err = 1'b0;

  logic unused_check_inputs;
  assign unused_check_inputs = ^{cp0_entryhi_i, cp0_entrylo0_i, cp0_entrylo1_i, cp0_mask_i};
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= ST_IDLE;
      op_q           <= OP_TLBP;
      idx_q          <= '0;
      cp0_index_o    <= '0;
      cp0_entryhi_o  <= '0;
      cp0_entrylo0_o <= '0;
      cp0_entrylo1_o <= '0;
      mask_q         <= '0;
    end else begin
      case (state_q)
        // IDLE: accept, sampling Random now so TLBWR uses the value seen at issue
        ST_IDLE: begin
          if (accept) begin
            op_q  <= tlb_op_e'(op_code);
            idx_q <= (tlb_op_e'(op_code) == OP_TLBWR) ? random_o : cp0_index_i;
            case (tlb_op_e'(op_code))
              OP_TLBP: state_q <= ST_PROBE;
              OP_TLBR: state_q <= ST_READ;
              default: state_q <= ST_WRITE;
            endcase
          end
        end
        // PROBE / READ: lookup result arrives this cycle; flush abandons it
        ST_PROBE: begin
          if (flush) begin
            state_q <= ST_IDLE;
          end else begin
            cp0_index_o <= probe_index;
            state_q     <= ST_COMMIT;
          end
        end
        ST_READ: begin
          if (flush) begin
            state_q <= ST_IDLE;
          end else begin
            cp0_entryhi_o  <= tlb_entryhi_i;
            cp0_entrylo0_o <= tlb_entrylo0_i;
            cp0_entrylo1_o <= tlb_entrylo1_i;
            mask_q         <= tlb_mask_i;
            state_q        <= ST_COMMIT;
          end
        end
        // WRITE onward: committed, flush no longer has any effect
        ST_WRITE: state_q <= ST_SETTLE;
        ST_SETTLE: begin
`ifdef TLB_WRITE_CHECK_EN
          state_q <= ST_CHECK;
`else
          state_q <= ST_COMMIT;
`endif
        end
        ST_CHECK:  state_q <= ST_COMMIT;
        ST_COMMIT: state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  assign op_ready       = (state_q == ST_IDLE);
  assign op_done        = (state_q == ST_COMMIT);
  assign tlb_we         = (state_q == ST_WRITE);
  assign tlb_index      = (state_q == ST_IDLE) ? '0 : idx_q;
  assign translate_hold = (state_q == ST_WRITE) || (state_q == ST_SETTLE) ||
                          (state_q == ST_CHECK);
  assign cp0_index_we   = (state_q == ST_COMMIT) && (op_q == OP_TLBP);
  assign cp0_read_we    = (state_q == ST_COMMIT) && (op_q == OP_TLBR);
  assign cp0_pagemask_o = {7'b0, mask_q, {PAGEMASK_LSB{1'b0}}};

endmodule

// File: tb/tb_tlb_op_ctrl.sv
// -----------------------------------------------------------------------------
// tb_tlb_op_ctrl
//  Self-checking bench for tlb_op_ctrl: table of directed TLB instructions
//  plus hand-written sequences for reset, Random/Wired and flush behaviour.
//  Build with TLB_WRITE_CHECK_EN defined to exercise the write-readback check.
// -----------------------------------------------------------------------------
module tb_tlb_op_ctrl;

  localparam logic [1:0] C_TLBP  = 2'b00;
  localparam logic [1:0] C_TLBR  = 2'b01;
  localparam logic [1:0] C_TLBWI = 2'b10;
  localparam logic [1:0] C_TLBWR = 2'b11;

`ifdef TLB_WRITE_CHECK_EN
  localparam int   WR_DONE = 4;
  localparam logic CHK     = 1'b1;
`else
  localparam int   WR_DONE = 3;
  localparam logic CHK     = 1'b0;
`endif

  localparam logic [31:0] HI_OK  = 32'h8000_2012;
  localparam logic [31:0] LO0_OK = 32'h0000_0047;
  localparam logic [31:0] LO1_OK = 32'h0000_0087;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'b00;
  logic        op_ready, op_done;
  logic        flush = 1'b0;
  logic [4:0]  cp0_index_i = '0;
  logic [4:0]  cp0_wired_i = '0;
  logic        cp0_wired_we = 1'b0;
  logic [31:0] cp0_entryhi_i = HI_OK;
  logic [31:0] cp0_entrylo0_i = LO0_OK;
  logic [31:0] cp0_entrylo1_i = LO1_OK;
  logic [11:0] cp0_mask_i = '0;
  logic        tlb_we;
  logic [4:0]  tlb_index;
  logic [31:0] tlb_probe_i = '0;
  logic [31:0] tlb_entryhi_i = HI_OK;
  logic [31:0] tlb_entrylo0_i = LO0_OK;
  logic [31:0] tlb_entrylo1_i = LO1_OK;
  logic [11:0] tlb_mask_i = '0;
  logic        cp0_index_we;
  logic [31:0] cp0_index_o;
  logic        cp0_read_we;
  logic [31:0] cp0_entryhi_o, cp0_entrylo0_o, cp0_entrylo1_o, cp0_pagemask_o;
  logic [4:0]  random_o;
  logic        translate_hold;
  logic        check_err;

  tlb_op_ctrl #(.TLB_NUM(32), .IDX_BITS(5)) dut (
    .clk(clk), .rst_n(rst_n), .op_valid(op_valid), .op_code(op_code),
    .op_ready(op_ready), .op_done(op_done), .flush(flush),
    .cp0_index_i(cp0_index_i), .cp0_wired_i(cp0_wired_i), .cp0_wired_we(cp0_wired_we),
    .cp0_entryhi_i(cp0_entryhi_i), .cp0_entrylo0_i(cp0_entrylo0_i),
    .cp0_entrylo1_i(cp0_entrylo1_i), .cp0_mask_i(cp0_mask_i),
    .tlb_we(tlb_we), .tlb_index(tlb_index), .tlb_probe_i(tlb_probe_i),
    .tlb_entryhi_i(tlb_entryhi_i), .tlb_entrylo0_i(tlb_entrylo0_i),
    .tlb_entrylo1_i(tlb_entrylo1_i), .tlb_mask_i(tlb_mask_i),
    .cp0_index_we(cp0_index_we), .cp0_index_o(cp0_index_o),
    .cp0_read_we(cp0_read_we), .cp0_entryhi_o(cp0_entryhi_o),
    .cp0_entrylo0_o(cp0_entrylo0_o), .cp0_entrylo1_o(cp0_entrylo1_o),
    .cp0_pagemask_o(cp0_pagemask_o), .random_o(random_o),
    .translate_hold(translate_hold), .check_err(check_err)
  );

  always #5 clk = ~clk;

  // Reference Random: reloads to 31 on Wired write, Wired >= 31 or at the floor.
  logic [4:0] m_rand;
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) m_rand <= 5'd31;
    else if (cp0_wired_we || cp0_wired_i >= 5'd31 || m_rand <= cp0_wired_i) m_rand <= 5'd31;
    else m_rand <= m_rand - 5'd1;
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", nm, act, exp);
    end
  endtask

  // Per-cycle log of one instruction; index 0 is the issue cycle T.
  logic we_l[0:8], hold_l[0:8], done_l[0:8], iwe_l[0:8], rwe_l[0:8], rdy_l[0:8], err_l[0:8];
  logic [4:0] idx_l[0:8];
  int done_cyc;

  task automatic run_op(input logic [1:0] op, input logic [4:0] idx, input int flush_cyc);
    @(negedge clk);
    op_valid = 1'b1; op_code = op; cp0_index_i = idx; flush = (flush_cyc == 0);
    rdy_l[0] = op_ready; we_l[0] = tlb_we; hold_l[0] = translate_hold; done_l[0] = op_done;
    iwe_l[0] = cp0_index_we; rwe_l[0] = cp0_read_we; idx_l[0] = tlb_index; err_l[0] = check_err;
    done_cyc = -1;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      op_valid = 1'b0;
      flush = (c == flush_cyc);
      rdy_l[c] = op_ready; we_l[c] = tlb_we; hold_l[c] = translate_hold; done_l[c] = op_done;
      iwe_l[c] = cp0_index_we; rwe_l[c] = cp0_read_we; idx_l[c] = tlb_index; err_l[c] = check_err;
      if (op_done && done_cyc < 0) done_cyc = c;
    end
    flush = 1'b0;
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [4:0]  idx;
    logic [31:0] probe;
    logic [31:0] rb_lo0;
    logic [11:0] rb_mask;
    int          exp_done;
    logic        exp_we;
    logic        exp_iwe;
    logic [31:0] exp_idx_o;
    logic        exp_rwe;
    logic [31:0] exp_lo0_o;
    logic [31:0] exp_pm_o;
    logic        exp_err;
  } vec_t;

  vec_t vecs[7];

  initial begin
    vecs[0] = '{C_TLBWI, 5'd5,  32'h0,         LO0_OK,       12'h000, WR_DONE, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0};
    vecs[1] = '{C_TLBP,  5'd3,  32'h0000_0007, LO0_OK,       12'h000, 2,       1'b0, 1'b1, 32'h0000_0007, 1'b0, 32'h0,         32'h0,         1'b0};
    vecs[2] = '{C_TLBP,  5'd3,  32'h8000_0000, LO0_OK,       12'h000, 2,       1'b0, 1'b1, 32'h8000_0000, 1'b0, 32'h0,         32'h0,         1'b0};
    vecs[3] = '{C_TLBP,  5'd0,  32'h0F00_0009, LO0_OK,       12'h000, 2,       1'b0, 1'b1, 32'h0000_0009, 1'b0, 32'h0,         32'h0,         1'b0};
    vecs[4] = '{C_TLBR,  5'd9,  32'h0,         32'h0000_1234, 12'hFFF, 2,      1'b0, 1'b0, 32'h0,         1'b1, 32'h0000_1234, 32'h01FF_E000, 1'b0};
    vecs[5] = '{C_TLBWI, 5'd31, 32'h0,         LO0_OK,       12'h000, WR_DONE, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         1'b0};
    vecs[6] = '{C_TLBWI, 5'd17, 32'h0,         32'h0000_0447, 12'h000, WR_DONE, 1'b1, 1'b0, 32'h0,         1'b0, 32'h0,         32'h0,         CHK};

    // Reset state
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_random",   32'(random_o), 32'd31);
    chk("rst_op_ready", 32'(op_ready), 32'd1);
    chk("rst_tlb_we",   32'(tlb_we), 32'd0);
    chk("rst_op_done",  32'(op_done), 32'd0);
    chk("rst_hold",     32'(translate_hold), 32'd0);
    chk("rst_check_err", 32'(check_err), 32'd0);

    // Directed instruction table
    for (int i = 0; i < 7; i++) begin
      tlb_probe_i    = vecs[i].probe;
      tlb_entrylo0_i = vecs[i].rb_lo0;
      tlb_mask_i     = vecs[i].rb_mask;
      run_op(vecs[i].op, vecs[i].idx, -1);
      chk($sformatf("v%0d_ready_T", i),  32'(rdy_l[0]), 32'd1);
      chk($sformatf("v%0d_done_cyc", i), 32'(done_cyc), 32'(vecs[i].exp_done));
      chk($sformatf("v%0d_we_T1", i),    32'(we_l[1]), 32'(vecs[i].exp_we));
      chk($sformatf("v%0d_we_T2", i),    32'(we_l[2]), 32'd0);
      chk($sformatf("v%0d_idx_T1", i),   32'(idx_l[1]), 32'(vecs[i].idx));
      chk($sformatf("v%0d_hold_T1", i),  32'(hold_l[1]), 32'(vecs[i].exp_we));
      chk($sformatf("v%0d_hold_T2", i),  32'(hold_l[2]), 32'(vecs[i].exp_we));
      if (done_cyc > 0 && done_cyc < 8) begin
        chk($sformatf("v%0d_hold_done", i),  32'(hold_l[done_cyc]), 32'd0);
        chk($sformatf("v%0d_ready_done", i), 32'(rdy_l[done_cyc]), 32'd0);
        chk($sformatf("v%0d_ready_after", i), 32'(rdy_l[done_cyc+1]), 32'd1);
        chk($sformatf("v%0d_done_len", i),   32'(done_l[done_cyc+1]), 32'd0);
        chk($sformatf("v%0d_index_we", i),   32'(iwe_l[done_cyc]), 32'(vecs[i].exp_iwe));
        chk($sformatf("v%0d_read_we", i),    32'(rwe_l[done_cyc]), 32'(vecs[i].exp_rwe));
        chk($sformatf("v%0d_check_err", i),  32'(err_l[done_cyc]), 32'(vecs[i].exp_err));
      end
      if (vecs[i].exp_iwe) chk($sformatf("v%0d_index_o", i), cp0_index_o, vecs[i].exp_idx_o);
      if (vecs[i].exp_rwe) begin
        chk($sformatf("v%0d_lo0_o", i), cp0_entrylo0_o, vecs[i].exp_lo0_o);
        chk($sformatf("v%0d_hi_o", i),  cp0_entryhi_o, HI_OK);
        chk($sformatf("v%0d_lo1_o", i), cp0_entrylo1_o, LO1_OK);
        chk($sformatf("v%0d_pm_o", i),  cp0_pagemask_o, vecs[i].exp_pm_o);
      end
    end
    tlb_entrylo0_i = LO0_OK;
    tlb_mask_i     = 12'h000;

    // TLBWR writes the Random value sampled at issue
    begin
      logic [4:0] exp_r;
      @(negedge clk);
      exp_r = m_rand;
      chk("wr_random_model", 32'(random_o), 32'(exp_r));
      op_valid = 1'b1; op_code = C_TLBWR; cp0_index_i = exp_r ^ 5'd3;
      @(negedge clk);
      op_valid = 1'b0;
      chk("wr_we",  32'(tlb_we), 32'd1);
      chk("wr_idx", 32'(tlb_index), 32'(exp_r));
      repeat (WR_DONE - 1) @(negedge clk);
      chk("wr_done", 32'(op_done), 32'd1);
    end

    // flush in IDLE blocks acceptance
    run_op(C_TLBWI, 5'd6, 0);
    chk("fl_idle_we",    32'(we_l[1]), 32'd0);
    chk("fl_idle_ready", 32'(rdy_l[1]), 32'd1);
    chk("fl_idle_done",  32'(done_cyc), 32'hFFFF_FFFF);

    // flush in READ kills the instruction
    run_op(C_TLBR, 5'd9, 1);
    begin
      logic any_rwe;
      any_rwe = 1'b0;
      for (int c = 0; c <= 8; c++) any_rwe |= rwe_l[c];
      chk("fl_read_rwe",   32'(any_rwe), 32'd0);
      chk("fl_read_done",  32'(done_cyc), 32'hFFFF_FFFF);
      chk("fl_read_ready", 32'(rdy_l[2]), 32'd1);
    end

    // flush in WRITE is ignored
    run_op(C_TLBWI, 5'd12, 1);
    chk("fl_write_we",   32'(we_l[1]), 32'd1);
    chk("fl_write_done", 32'(done_cyc), 32'(WR_DONE));

    // Random with Wired=4: 31..4 then 31; Wired write at 10 reloads
    @(negedge clk);
    cp0_wired_i = 5'd4; cp0_wired_we = 1'b1;
    @(negedge clk);
    cp0_wired_we = 1'b0;
    chk("rnd_reload", 32'(random_o), 32'd31);
    for (int k = 1; k <= 28; k++) begin
      @(negedge clk);
      chk($sformatf("rnd_seq%0d", k), 32'(random_o), (k <= 27) ? 32'(31 - k) : 32'd31);
    end
    repeat (21) @(negedge clk);
    chk("rnd_at10", 32'(random_o), 32'd10);
    cp0_wired_we = 1'b1;
    @(negedge clk);
    cp0_wired_we = 1'b0;
    chk("rnd_wired_we", 32'(random_o), 32'd31);

    // Wired >= TLB_NUM-1 pins Random at the top
    cp0_wired_i = 5'd31;
    repeat (3) @(negedge clk);
    chk("rnd_pinned", 32'(random_o), 32'd31);
    cp0_wired_i = 5'd0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
